// File: rtl/mem_arbiter.sv
// Three-requester SRAM arbiter: one access in flight, 1-cycle reads and 2-cycle writes.
// Define MEM_ARB_ROUND_ROBIN_EN for rotating priority; the default is fixed priority D > I > V.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        dReq,
  input  logic [1:0]  dCtrl,
  input  logic [15:0] dAddr,
  input  logic [15:0] dWdata,
  input  logic        iReq,
  input  logic [15:0] iAddr,
  input  logic        vReq,
  input  logic [15:0] vAddr,
  output logic        dAck,
  output logic        iAck,
  output logic        vAck,
  output logic [15:0] rdata,
  output logic [15:0] sramAddr,
  output logic [15:0] sramWdata,
  input  logic [15:0] sramRdata,
  output logic        sramOeN,
  output logic        sramWeN,
  output logic        sramDrive,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite1, StWrite2} arbState;

  arbState     state;
  logic [2:0]  grantQ;
  logic        dValid;
  logic [2:0]  eligible;
  logic [2:0]  grantSel;
  logic [15:0] selAddr;
  logic        selWrite;

  assign dValid = dReq && (dCtrl == 2'b01 || dCtrl == 2'b10);
  // A requester whose ack is high this cycle is still holding req; do not grant it again.
  assign eligible = {vReq && !vAck, iReq && !iAck, dValid && !dAck};
  assign busy = (state != StIdle);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rrPtr names the requester with highest priority for the next grant.
  logic [1:0] rrPtr;
  logic [1:0] rrNext;

  always_comb begin
    grantSel = 3'b000;
    case (rrPtr)
      2'd1: begin
        if (eligible[1])      grantSel = 3'b010;
        else if (eligible[2]) grantSel = 3'b100;
        else if (eligible[0]) grantSel = 3'b001;
      end
      2'd2: begin
        if (eligible[2])      grantSel = 3'b100;
        else if (eligible[0]) grantSel = 3'b001;
        else if (eligible[1]) grantSel = 3'b010;
      end
      default: begin
        if (eligible[0])      grantSel = 3'b001;
        else if (eligible[1]) grantSel = 3'b010;
        else if (eligible[2]) grantSel = 3'b100;
      end
    endcase
  end

  always_comb begin
    rrNext = 2'd0;
    unique case (grantSel)
      3'b001:  rrNext = 2'd1;
      3'b010:  rrNext = 2'd2;
      default: rrNext = 2'd0;
    endcase
  end
`else
  always_comb begin
    grantSel = 3'b000;
    if (eligible[0])      grantSel = 3'b001;
    else if (eligible[1]) grantSel = 3'b010;
    else if (eligible[2]) grantSel = 3'b100;
  end
`endif

  always_comb begin
    selAddr  = dAddr;
    selWrite = 1'b0;
    unique case (grantSel)
      3'b010:  selAddr = iAddr;
      3'b100:  selAddr = vAddr;
      default: begin
        selAddr  = dAddr;
        selWrite = (dCtrl == 2'b10);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= StIdle;
      grantQ    <= 3'b000;
      sramOeN   <= 1'b1;
      sramWeN   <= 1'b1;
      sramDrive <= 1'b0;
      dAck      <= 1'b0;
      iAck      <= 1'b0;
      vAck      <= 1'b0;
      rdata     <= 16'h0000;
      sramAddr  <= 16'h0000;
      sramWdata <= 16'h0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rrPtr     <= 2'd0;
`endif
    end else begin
      {vAck, iAck, dAck} <= 3'b000;
      case (state)
        StIdle: begin
          if (grantSel != 3'b000) begin
            grantQ   <= grantSel;
            sramAddr <= selAddr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rrPtr    <= rrNext;
`endif
            if (selWrite) begin
              sramWdata <= dWdata;
              sramDrive <= 1'b1;
              state     <= StWrite1;
            end else begin
              sramOeN <= 1'b0;
              state   <= StRead;
            end
          end
        end
        StRead: begin
          rdata              <= sramRdata;
          sramOeN            <= 1'b1;
          {vAck, iAck, dAck} <= grantQ;
          state              <= StIdle;
        end
        StWrite1: begin
          sramWeN <= 1'b0;
          state   <= StWrite2;
        end
        StWrite2: begin
          sramWeN   <= 1'b1;
          sramDrive <= 1'b0;
          dAck      <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM device model, timeline-based reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dReq, iReq, vReq;
  logic [1:0]  dCtrl;
  logic [15:0] dAddr, dWdata, iAddr, vAddr;
  logic        dAck, iAck, vAck;
  logic [15:0] rdata, sramAddr, sramWdata, sramRdata;
  logic        sramOeN, sramWeN, sramDrive, busy;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .dReq      (dReq),
    .dCtrl     (dCtrl),
    .dAddr     (dAddr),
    .dWdata    (dWdata),
    .iReq      (iReq),
    .iAddr     (iAddr),
    .vReq      (vReq),
    .vAddr     (vAddr),
    .dAck      (dAck),
    .iAck      (iAck),
    .vAck      (vAck),
    .rdata     (rdata),
    .sramAddr  (sramAddr),
    .sramWdata (sramWdata),
    .sramRdata (sramRdata),
    .sramOeN   (sramOeN),
    .sramWeN   (sramWeN),
    .sramDrive (sramDrive),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] mem    [0:65535];
  logic [15:0] refMem [0:65535];
  assign sramRdata = sramOeN ? 16'h0000 : mem[sramAddr];

  // Scheduled expectations, indexed by absolute cycle modulo 8.
  logic [2:0]  sAck   [8];
  logic        sOe    [8];
  logic        sWe    [8];
  logic        sDrv   [8];
  logic        sBusy  [8];
  logic        sSetA  [8];
  logic        sSetW  [8];
  logic        sSetR  [8];
  logic        sMemWr [8];
  logic [15:0] sAddr  [8];
  logic [15:0] sWd    [8];
  logic [15:0] sRd    [8];

  logic [15:0] eAddr, eWdata, eRdata;
  int          freeAt, ptr;
  bit          started;

  int          oeLowCnt = 0, weLowCnt = 0, ackCnt = 0;
  int          lastAckCyc [3];
  logic [17:0] logVal;
  int          remaining [3];

  function automatic logic [15:0] initVal(int a);
    return (a == 'h40) ? 16'h1234 : (16'(a) ^ 16'h5A5A);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void clearSlot(int k);
    sAck[k] = 3'b000; sOe[k] = 1'b0; sWe[k] = 1'b0; sDrv[k] = 1'b0; sBusy[k] = 1'b0;
    sSetA[k] = 1'b0; sSetW[k] = 1'b0; sSetR[k] = 1'b0; sMemWr[k] = 1'b0;
    sAddr[k] = 16'h0; sWd[k] = 16'h0; sRd[k] = 16'h0;
  endfunction

  // Reference model and per-cycle compare.
  initial begin : model
    int          s, g, n1, n2, n3;
    logic [2:0]  expAck;
    logic [2:0]  elig;
    logic [15:0] a;
    bit          isW;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = initVal(i);
      refMem[i] = initVal(i);
    end
    for (int k = 0; k < 8; k++) clearSlot(k);
    started = 0; freeAt = 0; ptr = 0;
    eAddr = 16'h0; eWdata = 16'h0; eRdata = 16'h0;
    forever begin
      @(negedge clk);
      s = cyc % 8;
      if (!sramWeN && sramDrive) mem[sramAddr] = sramWdata;
      expAck = 3'b000;
      if (started) begin
        if (sSetA[s])  eAddr  = sAddr[s];
        if (sSetW[s])  eWdata = sWd[s];
        if (sSetR[s])  eRdata = sRd[s];
        if (sMemWr[s]) refMem[sAddr[s]] = sWd[s];
        expAck = sAck[s];
        chk("acks", 32'({vAck, iAck, dAck}), 32'(expAck));
        chk("sramOeN", 32'(sramOeN), 32'(!sOe[s]));
        chk("sramWeN", 32'(sramWeN), 32'(!sWe[s]));
        chk("sramDrive", 32'(sramDrive), 32'(sDrv[s]));
        chk("busy", 32'(busy), 32'(sBusy[s]));
        chk("rdata", 32'(rdata), 32'(eRdata));
        if (sBusy[s]) chk("sramAddr", 32'(sramAddr), 32'(eAddr));
        if (sDrv[s])  chk("sramWdata", 32'(sramWdata), 32'(eWdata));
        if (!sramOeN) oeLowCnt++;
        if (!sramWeN) weLowCnt++;
        if (dAck) begin ackCnt++; lastAckCyc[0] = cyc; logVal = {logVal[15:0], 2'd1}; end
        if (iAck) begin ackCnt++; lastAckCyc[1] = cyc; logVal = {logVal[15:0], 2'd2}; end
        if (vAck) begin ackCnt++; lastAckCyc[2] = cyc; logVal = {logVal[15:0], 2'd3}; end
      end
      clearSlot(s);
      if (!rst) begin
        for (int k = 0; k < 8; k++) clearSlot(k);
        eAddr = 16'h0; eWdata = 16'h0; eRdata = 16'h0;
        freeAt = cyc + 1; ptr = 0; started = 1;
      end else if (started && cyc >= freeAt) begin
        elig[0] = dReq && (dCtrl == 2'b01 || dCtrl == 2'b10) && !expAck[0];
        elig[1] = iReq && !expAck[1];
        elig[2] = vReq && !expAck[2];
        g = -1;
        for (int k = 0; k < 3; k++) begin
          if (g < 0 && elig[(ptr + k) % 3]) g = (ptr + k) % 3;
        end
        if (g >= 0) begin
          a   = (g == 0) ? dAddr : (g == 1) ? iAddr : vAddr;
          isW = (g == 0) && (dCtrl == 2'b10);
          n1 = (cyc + 1) % 8; n2 = (cyc + 2) % 8; n3 = (cyc + 3) % 8;
          sBusy[n1] = 1'b1; sSetA[n1] = 1'b1; sAddr[n1] = a;
          if (isW) begin
            sDrv[n1] = 1'b1; sSetW[n1] = 1'b1; sWd[n1] = dWdata;
            sBusy[n2] = 1'b1; sDrv[n2] = 1'b1; sWe[n2] = 1'b1;
            sAck[n3] = 3'b001; sMemWr[n3] = 1'b1; sAddr[n3] = a; sWd[n3] = dWdata;
            freeAt = cyc + 3;
          end else begin
            sOe[n1] = 1'b1;
            sAck[n2] = 3'(1 << g); sSetR[n2] = 1'b1; sRd[n2] = refMem[a];
            freeAt = cyc + 2;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr = (g + 1) % 3;
`endif
        end
      end
      cyc++;
    end
  end

  task automatic drive();
    dReq = remaining[0] > 0;
    iReq = remaining[1] > 0;
    vReq = remaining[2] > 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (dAck && remaining[0] > 0) remaining[0]--;
    if (iAck && remaining[1] > 0) remaining[1]--;
    if (vAck && remaining[2] > 0) remaining[2]--;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(int budget);
    int n = 0;
    while ((remaining[0] + remaining[1] + remaining[2]) > 0 && n < budget) begin
      cycle();
      drive();
      n++;
    end
    if ((remaining[0] + remaining[1] + remaining[2]) > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d accesses still pending after %0d cycles",
               remaining[0] + remaining[1] + remaining[2], budget);
      remaining = '{0, 0, 0};
      drive();
    end
  endtask

  initial begin : stim
    int start, oe0, we0, ack0;
    rst = 1'b0; dReq = 1'b0; iReq = 1'b0; vReq = 1'b0; dCtrl = 2'b00;
    dAddr = 16'h0; dWdata = 16'h0; iAddr = 16'h0; vAddr = 16'h0;
    remaining = '{0, 0, 0};
    logVal = 18'h0;
    repeat (2) cycle();
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strobes", 32'({sramOeN, sramWeN, sramDrive}), 32'b110);
    chk("rst_acks", 32'({vAck, iAck, dAck}), 32'h0);
    chk("rst_bus", 32'({sramAddr, sramWdata}), 32'h0);
    rst = 1'b1;

    // Single instruction fetch.
    iAddr = 16'h0040; oe0 = oeLowCnt; start = cyc;
    remaining[1] = 1; drive();
    waitDone(20);
    chk("read_latency", 32'(lastAckCyc[1] - start), 32'd2);
    chk("read_oe_cycles", 32'(oeLowCnt - oe0), 32'd1);
    chk("read_rdata", 32'(rdata), 32'h1234);

    // Data write, then readback.
    dCtrl = 2'b10; dAddr = 16'h8000; dWdata = 16'hBEEF; we0 = weLowCnt; start = cyc;
    remaining[0] = 1; drive();
    waitDone(20);
    chk("write_latency", 32'(lastAckCyc[0] - start), 32'd3);
    chk("write_we_cycles", 32'(weLowCnt - we0), 32'd1);
    chk("write_keeps_rdata", 32'(rdata), 32'h1234);
    dCtrl = 2'b01;
    remaining[0] = 1; drive();
    waitDone(20);
    chk("readback", 32'(rdata), 32'hBEEF);

    // Request dropped right after grant still completes.
    vAddr = 16'h0123; start = cyc;
    vReq = 1'b1;
    cycle();
    vReq = 1'b0;
    repeat (3) cycle();
    chk("drop_latency", 32'(lastAckCyc[2] - start), 32'd2);
    chk("drop_rdata", 32'(rdata), 32'h5B79);

    // dCtrl=11 is not a request.
    dCtrl = 2'b11; ack0 = ackCnt; oe0 = oeLowCnt; we0 = weLowCnt;
    dReq = 1'b1;
    repeat (5) cycle();
    chk("noop_busy", 32'(busy), 32'h0);
    chk("noop_acks", 32'(ackCnt - ack0), 32'd0);
    chk("noop_strobes", 32'((oeLowCnt - oe0) + (weLowCnt - we0)), 32'd0);
    dReq = 1'b0;
    cycle();

    // Contention, each requester dropping after its ack.
    dCtrl = 2'b01; dAddr = 16'h0010; iAddr = 16'h0020; vAddr = 16'h0030;
    logVal = 18'h0;
    remaining = '{1, 1, 1}; drive();
    waitDone(40);
    chk("order_single", 32'(logVal), 32'(18'b011011));
    chk("order_rdata", 32'(rdata), 32'h5A6A);

    // Contention, three accesses each, requests held high.
    logVal = 18'h0;
    remaining = '{3, 3, 3}; drive();
    waitDone(100);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("order_held", 32'(logVal), 32'(18'b011011011011011011));
`else
    chk("order_held", 32'(logVal), 32'(18'b011001100110111111));
`endif
    cycle();

    // Reset during WRITE2 aborts the write.
    dCtrl = 2'b10; dAddr = 16'h9000; dWdata = 16'h1111; ack0 = ackCnt;
    remaining[0] = 1; drive();
    cycle();
    chk("abort_w1_weN", 32'(sramWeN), 32'h1);
    cycle();
    chk("abort_w2_weN", 32'(sramWeN), 32'h0);
    rst = 1'b0; remaining[0] = 0; drive();
    cycle();
    chk("abort_strobes", 32'({sramWeN, sramDrive}), 32'b10);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_dAck", 32'(dAck), 32'h0);
    rst = 1'b1;
    repeat (3) cycle();
    chk("abort_no_ack", 32'(ackCnt - ack0), 32'd0);

    // Mixed traffic checked by the model alone.
    for (int r = 0; r < 6; r++) begin
      dCtrl  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      dAddr  = 16'($urandom_range(0, 255));
      dWdata = 16'($urandom);
      iAddr  = 16'($urandom_range(0, 255));
      vAddr  = 16'($urandom_range(0, 255));
      remaining[0] = $urandom_range(0, 2);
      remaining[1] = $urandom_range(0, 2);
      remaining[2] = $urandom_range(1, 2);
      drive();
      waitDone(80);
    end

    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
